// File: rtl/matriz_celda_core.sv
// ---------------------------------------------------------------------------
// matriz_celda_core
//
// Compute core placed behind the matriz_celda AXI4-Lite register bank. It
// takes the slave's decoded register strobes and runs a signed 16x16
// multiply-accumulate over an operand stream. It also forwards each consumed
// operand pair so that cells can be chained into a systolic row.
//
// Register map (word index):
//   0 CTRL  W: bit0 start (self-clearing), bit1 clear, bit2 irq_en
//           R: bit0 busy, bit1 done, bit2 irq_en
//   1 LEN   beat count [LEN_WIDTH-1:0]
//   2 ACC   32-bit accumulator, read-only
//   3 STAT  beats accepted in the current or last run, read-only
//
// Ports:
//   ACLK, ARESET                 clock, asynchronous active-high reset
//   reg_wr_en/addr/data          one-cycle register write strobe
//   reg_rd_addr / reg_rd_data    combinational register read
//   s_valid/s_ready/s_data       operand stream, s_data = {a[31:16], b[15:0]}
//   m_valid/m_ready/m_data       forwarded copy of each accepted operand pair
//   irq                          level interrupt, done & irq_en
//
// Configuration macro:
//   MATRIZ_CELDA_FWD_EN  when defined, the forward register is built and
//                        s_ready waits for the downstream cell. When not
//                        defined, m_valid/m_data are tied to 0 and m_ready
//                        is ignored.
// ---------------------------------------------------------------------------
module matriz_celda_core #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 reg_wr_en,
    input  logic [1:0]           reg_wr_addr,
    input  logic [31:0]          reg_wr_data,
    input  logic [1:0]           reg_rd_addr,
    output logic [31:0]          reg_rd_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [31:0]          m_data,
    output logic                 irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    state_t state_q, state_d, base_state;

    logic [LEN_WIDTH-1:0] len_reg_q;   // software-visible LEN
    logic [LEN_WIDTH-1:0] len_q;       // length latched at start
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_inc;
    logic                 irq_en_q;
    logic [31:0]          acc_q;
    logic [31:0]          prod_q;
    logic                 prod_vld_q;  // prod_q holds a product still to be added
    logic [31:0]          prod_d;
    logic [31:0]          a_ext, b_ext;

    logic wr_ctrl, wr_len, start, clear, start_go;
    logic accept, last_beat, fwd_ok, busy, done;

    assign wr_ctrl = reg_wr_en && (reg_wr_addr == 2'd0);
    assign wr_len  = reg_wr_en && (reg_wr_addr == 2'd1);
    assign start   = wr_ctrl && reg_wr_data[0];
    assign clear   = wr_ctrl && reg_wr_data[1];

    // Clear is applied before start, so a combined write restarts from IDLE
    // with a zeroed accumulator.
    assign base_state = clear ? ST_IDLE : state_q;
    assign start_go   = start && ((base_state == ST_IDLE) || (base_state == ST_DONE));

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);
    assign irq  = done && irq_en_q;

    assign s_ready   = (state_q == ST_RUN) && (cnt_q < len_q) && fwd_ok;
    assign accept    = s_valid && s_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_beat = accept && (cnt_inc == len_q);

    // Sign-extend both halves to 32 bits; the low 32 bits of the product are
    // the exact signed 16x16 result.
    assign a_ext  = {{16{s_data[31]}}, s_data[31:16]};
    assign b_ext  = {{16{s_data[15]}}, s_data[15:0]};
    assign prod_d = a_ext * b_ext;

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = base_state;
        if (start_go) begin
            state_d = (len_reg_q == '0) ? ST_DONE : ST_RUN;
        end else begin
            case (base_state)
                ST_RUN:   if (last_beat) state_d = ST_DRAIN;
                ST_DRAIN: state_d = ST_DONE;
                default:  ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            len_reg_q  <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            irq_en_q   <= 1'b0;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
        end else begin
            if (wr_len)  len_reg_q <= reg_wr_data[LEN_WIDTH-1:0];
            if (wr_ctrl) irq_en_q  <= reg_wr_data[2];

            if (clear) begin
                acc_q      <= '0;
                prod_q     <= '0;
                prod_vld_q <= 1'b0;
                cnt_q      <= '0;
            end else begin
                if (prod_vld_q) acc_q <= acc_q + prod_q;
                prod_vld_q <= accept;
                if (accept) begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_inc;
                end
            end

            // A new run only starts from IDLE/DONE, where no beat is accepted.
            if (start_go) begin
                cnt_q <= '0;
                len_q <= len_reg_q;
            end
        end
    end

`ifdef MATRIZ_CELDA_FWD_EN
    logic        m_valid_q;
    logic [31:0] m_data_q;

    assign fwd_ok  = !m_valid_q || m_ready;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else if (clear) begin
            m_valid_q <= 1'b0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_data;
        end else if (m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

    logic unused_ok;
    assign unused_ok = ^reg_wr_data[31:LEN_WIDTH];
`else
    assign fwd_ok  = 1'b1;
    assign m_valid = 1'b0;
    assign m_data  = '0;

    logic unused_ok;
    assign unused_ok = ^{reg_wr_data[31:LEN_WIDTH], m_ready};
`endif

    always_comb begin
        reg_rd_data = '0;
        case (reg_rd_addr)
            2'd0: reg_rd_data = {29'd0, irq_en_q, done, busy};
            2'd1: reg_rd_data = {{(32-LEN_WIDTH){1'b0}}, len_reg_q};
            2'd2: reg_rd_data = acc_q;
            2'd3: reg_rd_data = {{(32-LEN_WIDTH){1'b0}}, cnt_q};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_matriz_celda_core.sv
// ---------------------------------------------------------------------------
// tb_matriz_celda_core
//
// Directed bench for matriz_celda_core. Inputs change 1 ns after the rising
// edge and outputs are sampled there too. Expected accumulator values come
// from a running model (model_acc) fed with the same operand pairs.
// ---------------------------------------------------------------------------
module tb_matriz_celda_core;

    localparam int LEN_WIDTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        reg_wr_en;
    logic [1:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic [1:0]  reg_rd_addr;
    logic [31:0] reg_rd_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        irq;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_acc;
    logic [31:0] rd;
    logic [31:0] p_max;

    matriz_celda_core #(.LEN_WIDTH(LEN_WIDTH)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .reg_rd_addr (reg_rd_addr),
        .reg_rd_data (reg_rd_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .irq         (irq)
    );

    always #10 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic reg_write(input logic [1:0] addr, input logic [31:0] data);
        reg_wr_en   = 1'b1;
        reg_wr_addr = addr;
        reg_wr_data = data;
        tick();
        reg_wr_en   = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [31:0] data);
        reg_rd_addr = addr;
        #1;
        data = reg_rd_data;
    endtask

    // Presents one operand pair and holds it until accepted; leaves s_valid
    // high so consecutive calls stream back-to-back.
    task automatic send_beat(input shortint a, input shortint b);
        bit got;
        int p;
        got     = 1'b0;
        s_data  = {a, b};
        s_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            if (s_ready) got = 1'b1;
            tick();
        end
        if (!got) check("beat_timeout", 32'd0, 32'd1);
        else begin
            p = int'(a) * int'(b);
            model_acc = model_acc + 32'(p);
        end
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] c;
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            reg_read(2'd0, c);
            if (c[1]) seen = 1'b1;
            else tick();
        end
        if (!seen) check(tag, 32'd0, 32'd1);
    endtask

    initial begin
        ARESET      = 1'b1;
        reg_wr_en   = 1'b0;
        reg_wr_addr = 2'd0;
        reg_wr_data = '0;
        reg_rd_addr = 2'd0;
        s_valid     = 1'b0;
        s_data      = '0;
        m_ready     = 1'b1;
        model_acc   = '0;

        // Reset state
        repeat (2) tick();
        ARESET = 1'b0;
        tick();
        reg_read(2'd0, rd); check("rst_ctrl", rd, 32'd0);
        reg_read(2'd1, rd); check("rst_len",  rd, 32'd0);
        reg_read(2'd2, rd); check("rst_acc",  rd, 32'd0);
        reg_read(2'd3, rd); check("rst_stat", rd, 32'd0);
        check("rst_irq",     {31'd0, irq},     32'd0);
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);

        // Run 1: four beats back-to-back, 1+6-20-14 = -27
        reg_write(2'd1, 32'd4);
        reg_read(2'd1, rd); check("len_rb", rd, 32'd4);
        reg_write(2'd0, 32'h1);
        reg_read(2'd0, rd); check("run1_busy", rd, 32'h1);
        send_beat(16'sd1, 16'sd1);
        send_beat(16'sd2, 16'sd3);
        send_beat(-16'sd4, 16'sd5);
        send_beat(16'sd7, -16'sd2);
        s_valid = 1'b0;
        // One cycle after the last accept: DRAIN, still busy
        reg_read(2'd0, rd); check("run1_drain", rd, 32'h1);
        check("run1_s_ready_off", {31'd0, s_ready}, 32'd0);
        tick();
        reg_read(2'd0, rd); check("run1_done", rd, 32'h2);
        reg_read(2'd2, rd); check("run1_acc",  rd, model_acc);
        check("run1_acc_const", model_acc, 32'hFFFF_FFE5);
        reg_read(2'd3, rd); check("run1_stat", rd, 32'd4);
`ifndef MATRIZ_CELDA_FWD_EN
        check("nofwd_m_valid", {31'd0, m_valid}, 32'd0);
        check("nofwd_m_data",  m_data, 32'd0);
`endif

        // Run 2 without clear: accumulates to -54
        reg_write(2'd0, 32'h1);
        send_beat(16'sd1, 16'sd1);
        send_beat(16'sd2, 16'sd3);
        send_beat(-16'sd4, 16'sd5);
        send_beat(16'sd7, -16'sd2);
        s_valid = 1'b0;
        wait_done("run2_done_timeout");
        reg_read(2'd2, rd); check("run2_acc", rd, 32'hFFFF_FFCA);

        // LEN=0 start with irq_en: done and irq right after the write
        reg_write(2'd1, 32'd0);
        reg_write(2'd0, 32'h5);
        reg_read(2'd0, rd); check("len0_ctrl", rd, 32'h6);
        check("len0_irq", {31'd0, irq}, 32'd1);
        reg_read(2'd2, rd); check("len0_acc_kept", rd, 32'hFFFF_FFCA);
        reg_read(2'd3, rd); check("len0_stat", rd, 32'd0);

        // Clear keeping irq_en: IDLE, acc 0, irq drops
        reg_write(2'd0, 32'h6);
        model_acc = '0;
        reg_read(2'd0, rd); check("clr_ctrl", rd, 32'h4);
        check("clr_irq", {31'd0, irq}, 32'd0);
        reg_read(2'd2, rd); check("clr_acc", rd, 32'd0);
        reg_write(2'd0, 32'h0);

`ifdef MATRIZ_CELDA_FWD_EN
        // Back-pressure on the forward port stalls the stream
        reg_write(2'd1, 32'd3);
        reg_write(2'd0, 32'h1);
        m_ready = 1'b0;
        send_beat(16'sd3, 16'sd4);
        s_data = {16'sd5, -16'sd6};
        check("fwd_stall_s_ready", {31'd0, s_ready}, 32'd0);
        check("fwd_stall_m_valid", {31'd0, m_valid}, 32'd1);
        tick();
        tick();
        check("fwd_hold_m_data", m_data, {16'sd3, 16'sd4});
        reg_read(2'd3, rd); check("fwd_stall_stat", rd, 32'd1);
        m_ready = 1'b1;
        send_beat(16'sd5, -16'sd6);
        check("fwd_beat1_data", m_data, {16'sd5, -16'sd6});
        send_beat(-16'sd2, -16'sd9);
        s_valid = 1'b0;
        check("fwd_beat2_data", m_data, {-16'sd2, -16'sd9});
        wait_done("fwd_done_timeout");
        reg_read(2'd2, rd); check("fwd_acc", rd, model_acc);
        reg_write(2'd0, 32'h2);
        model_acc = '0;
        check("fwd_clr_m_valid", {31'd0, m_valid}, 32'd0);
`endif

        // Abort mid-run with clear+start, then a full 8-beat run of max values
        reg_write(2'd1, 32'd8);
        reg_write(2'd0, 32'h1);
        send_beat(16'sh7FFF, 16'sh7FFF);
        send_beat(16'sh7FFF, 16'sh7FFF);
        s_valid = 1'b0;
        reg_write(2'd0, 32'h3);
        model_acc = '0;
        reg_read(2'd2, rd); check("abort_acc",  rd, 32'd0);
        reg_read(2'd3, rd); check("abort_stat", rd, 32'd0);
        reg_read(2'd0, rd); check("abort_busy", rd, 32'h1);
        // Start while busy is ignored: count keeps going
        for (int i = 0; i < 4; i++) send_beat(16'sh7FFF, 16'sh7FFF);
        s_valid = 1'b0;
        reg_write(2'd0, 32'h1);
        reg_read(2'd3, rd); check("busy_start_ignored", rd, 32'd4);
        for (int i = 0; i < 4; i++) send_beat(16'sh7FFF, 16'sh7FFF);
        s_valid = 1'b0;
        wait_done("max_done_timeout");
        reg_read(2'd2, rd); check("max_acc", rd, model_acc);
        p_max = 32'h3FFF_0001;
        check("max_acc_const", model_acc, p_max << 3);

        // Nine more runs: total 80 products, wraps modulo 2^32
        for (int r = 0; r < 9; r++) begin
            reg_write(2'd0, 32'h1);
            for (int i = 0; i < 8; i++) send_beat(16'sh7FFF, 16'sh7FFF);
            s_valid = 1'b0;
            wait_done("wrap_done_timeout");
        end
        reg_read(2'd2, rd); check("wrap_acc", rd, model_acc);
        check("wrap_acc_const", model_acc, p_max * 32'd80);
        reg_read(2'd3, rd); check("wrap_stat", rd, 32'd8);

        // Asynchronous reset in the middle of a run
        reg_write(2'd1, 32'd5);
        reg_write(2'd0, 32'h5);
        send_beat(16'sd9, 16'sd9);
        send_beat(16'sd9, 16'sd9);
        s_valid = 1'b0;
        ARESET = 1'b1;
        #1;
        reg_read(2'd0, rd); check("arst_ctrl", rd, 32'd0);
        reg_read(2'd1, rd); check("arst_len",  rd, 32'd0);
        reg_read(2'd2, rd); check("arst_acc",  rd, 32'd0);
        reg_read(2'd3, rd); check("arst_stat", rd, 32'd0);
        check("arst_s_ready", {31'd0, s_ready}, 32'd0);
        ARESET = 1'b0;
        tick();
        tick();
        reg_read(2'd0, rd); check("arst_no_complete", rd, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
